// File: rtl/rsa_host_ctrl.sv
// Host command controller for the RSA exponentiation core: operand registers, modulus check, engine clear, result capture.
// Latency: start -> 1-cycle CLEAR -> RUN until eng_eoc or watchdog abort. Backpressure: none; ena stalls all state.
module rsa_host_ctrl #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 256
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             ena,
    input  logic             wr_en,
    input  logic [1:0]       wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] op_m,
    output logic [WIDTH-1:0] op_e,
    output logic [WIDTH-1:0] op_n,
    output logic [WIDTH-1:0] op_const,
    output logic             eng_clear,
    input  logic             eng_eoc,
    input  logic [WIDTH-1:0] eng_result,
    output logic [WIDTH-1:0] result
);
    localparam int WDW = $clog2(TIMEOUT);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN, S_ABORT} state_t;

    state_t           state_q, state_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             clr_q, clr_d;
    logic [WDW-1:0]   wd_q, wd_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] m_q, m_d, e_q, e_d, n_q, n_d, c_q, c_d;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q  <= S_IDLE;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            clr_q    <= 1'b0;
            wd_q     <= '0;
            result_q <= '0;
            m_q      <= '0;
            e_q      <= '0;
            n_q      <= '0;
            c_q      <= '0;
        end else if (ena) begin
            state_q  <= state_d;
            done_q   <= done_d;
            err_q    <= err_d;
            clr_q    <= clr_d;
            wd_q     <= wd_d;
            result_q <= result_d;
            m_q      <= m_d;
            e_q      <= e_d;
            n_q      <= n_d;
            c_q      <= c_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        done_d   = done_q;
        err_d    = err_q;
        clr_d    = clr_q;
        wd_d     = wd_q;
        result_d = result_q;
        m_d      = m_q;
        e_d      = e_q;
        n_d      = n_q;
        c_d      = c_q;
        case (state_q)
            S_IDLE: begin
                if (wr_en) begin
                    done_d = 1'b0;
                    case (wr_addr)
                        2'd0: m_d = wr_data;
                        2'd1: e_d = wr_data;
                        2'd2: n_d = wr_data;
                        2'd3: c_d = wr_data;
                    endcase
                end
                // An odd modulus is necessarily nonzero; the check uses the pre-write N.
                if (start) begin
                    if (n_q[0]) begin
                        done_d  = 1'b0;
                        err_d   = 1'b0;
                        clr_d   = 1'b0;
                        state_d = S_CLEAR;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_CLEAR: begin
                wd_d    = '0;
                clr_d   = 1'b1;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (eng_eoc) begin
                    result_d = eng_result;
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end else if (wd_q == WD_LAST) begin
                    clr_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_ABORT;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_ABORT: begin
                err_d   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (state_q != S_IDLE && (wr_en || start)) begin
            err_d = 1'b1;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign err       = err_q;
    assign eng_clear = clr_q;
    assign result    = result_q;
    assign op_m      = m_q;
    assign op_e      = e_q;
    assign op_n      = n_q;
    assign op_const  = c_q;
endmodule

// File: tb/tb_rsa_host_ctrl.sv
// Scoreboard bench for rsa_host_ctrl with a behavioural modexp engine model.
module tb_rsa_host_ctrl;
    localparam int W  = 8;
    localparam int TO = 48;

    logic         clk = 1'b0;
    logic         rstb, ena, wr_en, start, eng_eoc;
    logic [1:0]   wr_addr;
    logic [W-1:0] wr_data, eng_result;
    logic         busy, done, err, eng_clear;
    logic [W-1:0] op_m, op_e, op_n, op_const, result;

    rsa_host_ctrl #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rstb(rstb), .ena(ena), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start), .busy(busy), .done(done), .err(err),
        .op_m(op_m), .op_e(op_e), .op_n(op_n), .op_const(op_const),
        .eng_clear(eng_clear), .eng_eoc(eng_eoc), .eng_result(eng_result), .result(result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        logic         done;
        logic         err;
        int           bcyc;
        int           clow;
    } exp_t;

    exp_t         q[$];
    int           n_cmp = 0;
    int           n_fail = 0;
    logic [W-1:0] ref_op[4];
    logic [W-1:0] ref_res;
    int           eng_lat = -1;
    int           eng_cnt = 0;

    function automatic logic [W-1:0] modexp(input logic [W-1:0] m, input logic [W-1:0] e,
                                            input logic [W-1:0] n);
        longint r, b;
        if (n == 0) return '0;
        r = 1 % longint'(n);
        b = longint'(m) % longint'(n);
        for (int i = 0; i < W; i++) begin
            if (e[i]) r = (r * b) % longint'(n);
            b = (b * b) % longint'(n);
        end
        return r[W-1:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Engine model: raises eoc after eng_lat enabled cycles out of clear; stalls with ena.
    always @(negedge clk) begin
        if (!eng_clear) begin
            eng_cnt    = 0;
            eng_eoc    = 1'b0;
            eng_result = W'($urandom);
        end else begin
            eng_eoc    = (eng_lat >= 0 && eng_cnt == eng_lat);
            eng_result = eng_eoc ? modexp(op_m, op_e, op_n) : W'($urandom);
            if (ena) eng_cnt++;
        end
    end

    // Monitor: each busy fall is one completed command, compared against the queue head.
    int mon_b = 0, mon_l = 0;
    logic mon_prev = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rstb) begin
            mon_b = 0; mon_l = 0; mon_prev = 1'b0;
        end else begin
            if (busy) begin
                mon_b++;
                if (!eng_clear) mon_l++;
            end else if (mon_prev) begin
                if (q.size() == 0) begin
                    chk("unexpected_completion", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("result", 32'(result), 32'(e.res));
                    chk("done", 32'(done), 32'(e.done));
                    chk("err", 32'(err), 32'(e.err));
                    chk("busy_cycles", mon_b, e.bcyc);
                    chk("clear_low_cycles", mon_l, e.clow);
                end
                mon_b = 0; mon_l = 0;
            end
            mon_prev = busy;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [W-1:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
        ref_op[a] = d;
    endtask

    task automatic start_run(input int lat, input logic exp_err, input int extra);
        exp_t e;
        eng_lat = lat;
        if (lat >= 0 && lat <= TO - 1) begin
            ref_res = modexp(ref_op[0], ref_op[1], ref_op[2]);
            e = '{res: ref_res, done: 1'b1, err: exp_err, bcyc: lat + 2 + extra, clow: 1};
        end else begin
            e = '{res: ref_res, done: 1'b0, err: 1'b1, bcyc: TO + 2 + extra, clow: 2};
        end
        q.push_back(e);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_rise", 32'(busy), 32'd1);
        chk("clear_low_at_start", 32'(eng_clear), 32'd0);
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (!busy) begin
                tick();
                return;
            end
            tick();
        end
        chk("wait_idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_result"}, 32'(result), 32'd0);
        chk({tag, "_eng_clear"}, 32'(eng_clear), 32'd0);
        chk({tag, "_ops"}, {op_m, op_e, op_n, op_const}, 32'd0);
    endtask

    initial begin
        rstb = 1'b0; ena = 1'b1; wr_en = 1'b0; start = 1'b0;
        wr_addr = '0; wr_data = '0; eng_eoc = 1'b0; eng_result = '0;
        for (int i = 0; i < 4; i++) ref_op[i] = '0;
        ref_res = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");
        rstb = 1'b1;
        tick();

        // Even modulus rejected straight after reset
        wr(2'd2, 8'h8E);
        start = 1'b1; tick(); start = 1'b0;
        chk("even_n_err", 32'(err), 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk("even_n_busy", 32'(busy), 32'd0);
            chk("even_n_clear", 32'(eng_clear), 32'd0);
            tick();
        end

        // Normal run
        wr(2'd0, 8'h09); wr(2'd1, 8'h07); wr(2'd2, 8'h8F);
        wr(2'd3, W'((longint'(1) << (2 * W)) % 143));
        chk("const_reg", 32'(op_const), 32'h2A);
        start_run(40, 1'b0, 0);
        wait_idle(200);
        chk("normal_result", 32'(result), 32'h30);
        chk("clear_held_after_run", 32'(eng_clear), 32'd1);

        // IDLE write clears done; zero modulus rejected
        wr(2'd2, 8'h00);
        chk("write_clears_done", 32'(done), 32'd0);
        start = 1'b1; tick(); start = 1'b0;
        chk("zero_n_err", 32'(err), 32'd1);
        chk("zero_n_busy", 32'(busy), 32'd0);
        wr(2'd2, 8'h8F);

        // Watchdog abort, then boundary race where eoc wins
        start_run(-1, 1'b1, 0);
        wait_idle(200);
        chk("clear_low_after_abort", 32'(eng_clear), 32'd0);
        start_run(TO - 1, 1'b0, 0);
        wait_idle(200);

        // Writes and start while busy are rejected
        start_run(20, 1'b1, 0);
        repeat (5) tick();
        wr_en = 1'b1; wr_addr = 2'd1; wr_data = 8'hFF; start = 1'b1;
        tick();
        wr_en = 1'b0; start = 1'b0;
        chk("busy_write_ignored", 32'(op_e), 32'(ref_op[1]));
        chk("busy_write_err", 32'(err), 32'd1);
        wait_idle(200);
        start_run(10, 1'b0, 0);
        chk("accepted_start_clears_err", 32'(err), 32'd0);
        wait_idle(200);

        // Clock-enable freeze extends the run without tripping the watchdog
        start_run(40, 1'b0, 10);
        repeat (8) tick();
        ena = 1'b0;
        repeat (10) tick();
        ena = 1'b1;
        wait_idle(200);

        // Randomised runs
        for (int it = 0; it < 8; it++) begin
            wr(2'd0, W'($urandom));
            wr(2'd1, W'($urandom));
            wr(2'd2, W'($urandom) | 8'h01);
            wr(2'd3, W'($urandom));
            chk("rand_ops", {op_m, op_e, op_n, op_const},
                {ref_op[0], ref_op[1], ref_op[2], ref_op[3]});
            start_run(int'($urandom_range(0, 30)), 1'b0, 0);
            wait_idle(200);
        end
        chk("queue_drained", q.size(), 32'd0);

        // Asynchronous reset mid-run
        start_run(40, 1'b0, 0);
        repeat (10) tick();
        rstb = 1'b0;
        #1;
        check_reset("midrun_reset");
        q.delete();
        for (int i = 0; i < 4; i++) ref_op[i] = '0;
        ref_res = '0;
        eng_lat = -1;
        tick();
        rstb = 1'b1;
        repeat (3) tick();
        chk("post_reset_idle", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/rsa_host_ctrl.md
# rsa_host_ctrl

Host-side command controller for the RSA exponentiation core. It holds the operand registers (message, exponent, modulus, mapping constant) and checks the modulus before each run. It drives the engine's active-low synchronous clear to launch one modular exponentiation, then waits for end-of-conversion and captures the result. A watchdog aborts runs that never complete. It sits between the byte-level host interface and the `rsa_control`/MMM datapath, and is the only block that toggles the engine's clear.

## Interface

Parameters:
- `WIDTH`, 8: operand/result width in bits.
- `TIMEOUT`, 256: maximum RUN cycles before abort; must be ≥ 2.

Ports:
- `clk`  in  1  system clock, all logic on rising edge.
- `rstb`  in  1  reset, asynchronous, active-low.
- `ena`  in  1  clock enable; when 0, every register (state, operands, watchdog, flags) holds.
- `wr_en`  in  1  operand write strobe.
- `wr_addr`  in  2  operand select: 0=M, 1=E, 2=N, 3=CONST.
- `wr_data`  in  WIDTH  operand write data.
- `start`  in  1  run request, sampled each enabled cycle.
- `busy`  out  1  run in progress (states CLEAR, RUN, ABORT).
- `done`  out  1  sticky, result valid.
- `err`  out  1  sticky error flag.
- `op_m`, `op_e`, `op_n`, `op_const`  out  WIDTH each  registered operands to the engine.
- `eng_clear`  out  1  engine clear, active-low; 0 holds the engine FSM in reset.
- `eng_eoc`  in  1  engine end-of-conversion pulse.
- `eng_result`  in  WIDTH  engine result, valid when `eng_eoc`=1.
- `result`  out  WIDTH  captured result.

## Operation

- **States:** IDLE, CLEAR, RUN, ABORT. All outputs are registered or decoded from state (Moore). Nothing is combinational from inputs.
- **Reset values:** state=IDLE, `busy`=0, `done`=0, `err`=0, `result`=0, all operands=0, `eng_clear`=0, watchdog=0.
- **Writes:**
  - In IDLE, `wr_en`=1 loads `wr_data` into the addressed operand and clears `done`.
  - In any other state, the write is ignored and `err` is set.
- **Start acceptance:** `start`=1 in IDLE is accepted only if `op_n` is odd and nonzero (Montgomery precondition). The check uses the value registered before the current edge.
- **Accepted start:** `done`←0, `err`←0, then go to CLEAR.
- **Rejected start:**
  - Even or zero N: `err`←1, stay in IDLE.
  - `start` while `busy`=1: `err`←1, the run continues unaffected.
- **CLEAR (1 cycle):**
  - `eng_clear`=0, watchdog←0, then go to RUN.
- **RUN:**
  - `eng_clear`=1; the watchdog increments by 1 per enabled cycle.
  - On `eng_eoc`=1: `result`←`eng_result`, `done`←1, go to IDLE.
  - Else, if the watchdog equals TIMEOUT-1: go to ABORT.
- **ABORT (1 cycle):** `eng_clear`=0, `err`←1, `done` stays 0, then go to IDLE.
- **IDLE:**
  - After a completed run, `eng_clear` stays 1 so the engine remains in its own idle state.
  - After reset or abort, `eng_clear` stays 0 until the next CLEAR→RUN.
- **Watchdog:** width is `$clog2(TIMEOUT)` bits and it never wraps; it is only compared in RUN.

## Timing

- **Start latency:** `start` sampled at edge k (in IDLE) → `busy`=1 and `eng_clear`=0 from k+1 → `eng_clear`=1 from k+2.
- **Completion:** `eng_eoc` sampled at edge j → `result`, `done`=1 and `busy`=0 visible after j.
- **Simultaneous `eng_eoc` and final watchdog count:** `eng_eoc` wins (capture, no error).
- **Simultaneous `wr_en` and accepted `start` in IDLE:** the write lands at the same edge. The engine sees the new operand because operands are stable from CLEAR onward. The N check uses the old N.
- **`ena`=0 mid-RUN:** the watchdog and state freeze, and an `eng_eoc` arriving then is not sampled. The engine shares `ena`, so `eng_eoc` is held.
- **`rstb` asserted mid-run:** immediate return to reset values, and `eng_clear`=0 aborts the engine asynchronously-safe.
- **Operands** never change while `busy`=1.

## Test plan

- **Normal run:** reset, write M=0x09, E=0x07, N=0x8F, CONST=model value, pulse `start`; the engine model returns 0x30 after 40 cycles → `eng_clear` low for exactly 1 cycle, `busy` high 42 cycles, `result`=0x30, `done`=1, `err`=0.
- **Modulus check:** write N=0x8E, then N=0x00, pulsing `start` after each → `err`=1, `busy` never rises, `eng_clear` stays 0.
- **Timeout:** TIMEOUT=16, the engine model never raises `eng_eoc` → ABORT after 16 RUN cycles, `eng_clear`=0 for 1 cycle, `err`=1, `done`=0, back to IDLE.
- **Boundary race:** raise `eng_eoc` on the cycle the watchdog equals TIMEOUT-1 → `result` captured, `done`=1, `err`=0.
- **Busy protection:** `wr_en` with addr 1, data 0xFF, plus `start`, both during RUN → `op_e` unchanged, `err`=1, the run completes with the correct result. The next accepted start clears `err`.
- **Freeze and reset:** drop `ena` for 10 cycles mid-RUN → run length extends by 10, no timeout. Then assert `rstb` mid-RUN → all outputs return to reset values, including `eng_clear`=0.
